bus_cycle_ctrl: RTL and testbench
=================================

// Module: bus_cycle_ctrl
// PURPOSE
//  Sequences every 6809-side bus cycle onto the on-chip data bus. Decodes
//  the address into one-hot ROM/RAM/USB selects and inserts per-region wait
//  states. Holds the CPU (mrdy) until the USB ACIA reports ready, then
//  latches read data from the data-bus mux output. Sits between the CPU
//  interface and the read mux and memories.
// PARAMETERS
//  ROM_BASE  16'hE000  ROM decode base; region is ROM_BASE..16'hFFFF
//  USB_BASE  16'hA000  USB ACIA base; 2 bytes, USB_BASE..USB_BASE+1
//  RAM_TOP   16'h7FFF  RAM decode is 16'h0000..RAM_TOP
//  ROM_WS    0         ROM wait states (0..15)
//  RAM_WS    1         RAM wait states (0..15)
//  USB_WS    2         USB wait states (0..15), minimum before ready is sampled
//  TIMEOUT   255       USB ready timeout in cycles (used only with BUS_TIMEOUT_EN)
// PORTS
//  clk         in   1   system clock
//  reset_n     in   1   asynchronous active-low reset
//  cycle_req   in   1   1-clk pulse: start a bus cycle; addr/rw/wdata valid with it
//  cpu_addr    in   16  CPU address
//  cpu_rw      in   1   1 = read, 0 = write
//  cpu_wdata   in   8   CPU write data
//  bus_rdata   in   8   read data from the data-bus mux (0xFF when nothing selected)
//  usb_ready   in   1   ACIA ready; sampled only in USB cycles
//  rom_select  out  1   ROM select, one-hot with ram_select and usb_select
//  ram_select  out  1   RAM select
//  usb_select  out  1   USB ACIA select
//  ram_we_n    out  1   RAM write strobe, active low
//  bus_wdata   out  8   registered write data to memories/peripherals
//  cpu_rdata   out  8   latched read data, valid from cycle_done onward
//  mrdy        out  1   0 = stretch CPU; low from cycle_req accept until cycle_done
//  cycle_done  out  1   1-clk pulse: cycle complete
//  bus_error   out  1   sticky USB timeout flag (tied 0 without BUS_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE; all selects 0, ram_we_n=1, mrdy=1,
//   cycle_done=0, cpu_rdata=8'hFF, bus_wdata=0, bus_error=0; wait counter=0.
//   Reset mid-cycle aborts it immediately; no done pulse follows.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE: on cycle_req, register addr/rw/wdata, decode region, load the
//   counter with that region's WS, set mrdy=0, then go to ACCESS.
//  Decode priority: ROM > USB > RAM > unmapped. Unmapped: no select, WS=0.
//  ACCESS: the region's select is held high throughout.
//   - RAM write: ram_we_n=0 for every ACCESS cycle.
//   - The counter decrements each cycle while nonzero.
//   - Exit when counter==0 and (region!=USB or usb_ready==1).
//   - Read exit: cpu_rdata <= bus_rdata on the exit edge.
//   - Next state is DONE.
//  DONE: selects=0, ram_we_n=1, cycle_done=1, mrdy=1, then go to IDLE.
//  Latency: req at T0, done at T0+WS+2 (USB: plus cycles waiting for ready).
//  A ROM write completes normally with no side effect. An unmapped read
//   returns 8'hFF.
//  cycle_req while not IDLE (including in DONE) is ignored; there is no queueing.
//  A WS value above 15 is clamped to 15. The counter is 4 bits.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined:
//   - An 8-bit counter runs once the USB counter reaches 0.
//   - If usb_ready stays low for TIMEOUT cycles, exit to DONE and set
//     cpu_rdata=8'hFF (read) and bus_error=1.
//   - bus_error is cleared only by reset.
//  BUS_TIMEOUT_EN undefined: the controller waits on usb_ready indefinitely;
//   bus_error is constant 0.
// TESTING
//  ROM read 0xFFFE, bus_rdata=0x5A -> rom_select high 1 cycle, done at T0+2,
//   cpu_rdata=0x5A, mrdy low exactly 2 cycles.
//  RAM write 0x1234 data 0xC3 -> ram_select + ram_we_n=0 for 2 cycles,
//   bus_wdata=0xC3, done at T0+3.
//  USB read 0xA001, usb_ready low 5 cycles after WS -> usb_select held,
//   done at T0+9, cpu_rdata=bus_rdata.
//  Unmapped read 0x9000 -> no select, cpu_rdata=0xFF, done at T0+2.
//  reset_n low mid RAM cycle -> selects/we drop same cycle, no done, mrdy=1.
//  BUS_TIMEOUT_EN, TIMEOUT=4, usb_ready stuck 0 -> done after timeout,
//   cpu_rdata=0xFF, bus_error=1 and held.

Source files
------------

// File: rtl/bus_cycle_ctrl_if.sv
// CPU-side bus cycle bundle between the 6809 interface and bus_cycle_ctrl.
interface bus_cycle_ctrl_if;
    logic        cycle_req;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic [7:0]  bus_rdata;
    logic        usb_ready;
    logic        rom_select;
    logic        ram_select;
    logic        usb_select;
    logic        ram_we_n;
    logic [7:0]  bus_wdata;
    logic [7:0]  cpu_rdata;
    logic        mrdy;
    logic        cycle_done;
    logic        bus_error;

    modport master (
        output cycle_req, cpu_addr, cpu_rw, cpu_wdata, bus_rdata, usb_ready,
        input  rom_select, ram_select, usb_select, ram_we_n, bus_wdata,
               cpu_rdata, mrdy, cycle_done, bus_error
    );

    modport slave (
        input  cycle_req, cpu_addr, cpu_rw, cpu_wdata, bus_rdata, usb_ready,
        output rom_select, ram_select, usb_select, ram_we_n, bus_wdata,
               cpu_rdata, mrdy, cycle_done, bus_error
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 6809 bus cycle sequencer: region decode, wait states, USB ready hold-off.
// Optional USB ready timeout with sticky bus_error when BUS_TIMEOUT_EN is defined.
module bus_cycle_ctrl #(
    parameter logic [15:0] ROM_BASE = 16'hE000,
    parameter logic [15:0] USB_BASE = 16'hA000,
    parameter logic [15:0] RAM_TOP  = 16'h7FFF,
    parameter int unsigned ROM_WS   = 0,
    parameter int unsigned RAM_WS   = 1,
    parameter int unsigned USB_WS   = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    bus_cycle_ctrl_if.slave  bus
);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] ROM_WS_C = (ROM_WS > 15) ? 4'd15 : CW'(ROM_WS);
    localparam logic [CW-1:0] RAM_WS_C = (RAM_WS > 15) ? 4'd15 : CW'(RAM_WS);
    localparam logic [CW-1:0] USB_WS_C = (USB_WS > 15) ? 4'd15 : CW'(USB_WS);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;
    typedef enum logic [1:0] {RG_NONE, RG_ROM, RG_RAM, RG_USB} region_t;

    state_t        state_q, state_d;
    region_t       region_q, region_d, dec_region;
    logic [CW-1:0] cnt_q, cnt_d, dec_ws;
    logic          rw_q, rw_d;
    logic [7:0]    wdata_q, wdata_d, rdata_q, rdata_d;
    logic          rom_q, rom_d, ram_q, ram_d, usb_q, usb_d;
    logic          we_n_q, we_n_d, mrdy_q, mrdy_d, done_q, done_d;
    logic          exit_ok, timed_out;

    // Region decode, ROM > USB > RAM > unmapped
    always_comb begin
        dec_region = RG_NONE;
        dec_ws     = '0;
        if (bus.cpu_addr >= ROM_BASE) begin
            dec_region = RG_ROM;
            dec_ws     = ROM_WS_C;
        end else if (bus.cpu_addr == USB_BASE || bus.cpu_addr == USB_BASE + 16'd1) begin
            dec_region = RG_USB;
            dec_ws     = USB_WS_C;
        end else if (bus.cpu_addr <= RAM_TOP) begin
            dec_region = RG_RAM;
            dec_ws     = RAM_WS_C;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO_C = (TIMEOUT > 255) ? 255 : TIMEOUT;
    localparam logic [7:0]  TO_LAST = (TO_C == 0) ? 8'd0 : 8'(TO_C - 1);
    logic [7:0] to_cnt_q, to_cnt_d;
    logic       err_q, err_d;

    // Ready-wait timer, armed only once the USB wait states have elapsed
    always_comb begin
        to_cnt_d  = to_cnt_q;
        timed_out = 1'b0;
        if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (state_q == ST_ACCESS && cnt_q == '0 &&
                     region_q == RG_USB && !bus.usb_ready) begin
            if (to_cnt_q == TO_LAST) timed_out = 1'b1;
            else                     to_cnt_d  = to_cnt_q + 8'd1;
        end
        err_d = err_q | timed_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.bus_error = err_q;
`else
    assign timed_out     = 1'b0;
    assign bus.bus_error = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rom_d    = rom_q;
        ram_d    = ram_q;
        usb_d    = usb_q;
        we_n_d   = we_n_q;
        mrdy_d   = mrdy_q;
        done_d   = 1'b0;
        exit_ok  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cycle_req) begin
                    state_d  = ST_ACCESS;
                    region_d = dec_region;
                    cnt_d    = dec_ws;
                    rw_d     = bus.cpu_rw;
                    wdata_d  = bus.cpu_wdata;
                    rom_d    = (dec_region == RG_ROM);
                    ram_d    = (dec_region == RG_RAM);
                    usb_d    = (dec_region == RG_USB);
                    we_n_d   = !(dec_region == RG_RAM && !bus.cpu_rw);
                    mrdy_d   = 1'b0;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
                else exit_ok = (region_q != RG_USB) || bus.usb_ready;
                if (exit_ok || timed_out) begin
                    state_d = ST_DONE;
                    rom_d   = 1'b0;
                    ram_d   = 1'b0;
                    usb_d   = 1'b0;
                    we_n_d  = 1'b1;
                    mrdy_d  = 1'b1;
                    done_d  = 1'b1;
                    if (rw_q)
                        rdata_d = (region_q == RG_NONE || timed_out) ? 8'hFF : bus.bus_rdata;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            region_q <= RG_NONE;
            cnt_q    <= '0;
            rw_q     <= 1'b1;
            wdata_q  <= '0;
            rdata_q  <= 8'hFF;
            rom_q    <= 1'b0;
            ram_q    <= 1'b0;
            usb_q    <= 1'b0;
            we_n_q   <= 1'b1;
            mrdy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rom_q    <= rom_d;
            ram_q    <= ram_d;
            usb_q    <= usb_d;
            we_n_q   <= we_n_d;
            mrdy_q   <= mrdy_d;
            done_q   <= done_d;
        end
    end

    // mrdy also drops in the accepting cycle so the CPU is stretched immediately
    assign bus.mrdy       = mrdy_q & ~(state_q == ST_IDLE && bus.cycle_req);
    assign bus.rom_select = rom_q;
    assign bus.ram_select = ram_q;
    assign bus.usb_select = usb_q;
    assign bus.ram_we_n   = we_n_q;
    assign bus.bus_wdata  = wdata_q;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.cycle_done = done_q;
endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl; timeout scenario runs when BUS_TIMEOUT_EN is defined.
module tb_bus_cycle_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   passed = 0;

    bus_cycle_ctrl_if bif ();

    bus_cycle_ctrl #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    // result record of the last run_cycle
    int         r_done_k, r_n_done, r_rom, r_ram, r_usb, r_we, r_mrdy;
    logic [7:0] r_rdata, r_wdata;

    // k = 0 is the request cycle; outputs sampled mid-cycle
    task automatic run_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input logic [7:0] rd, input int ready_at, input int req_len,
                             input int budget);
        r_done_k = -1; r_n_done = 0; r_rom = 0; r_ram = 0; r_usb = 0; r_we = 0; r_mrdy = 0;
        r_rdata = 8'h00; r_wdata = 8'h00;
        for (int k = 0; k < budget; k++) begin
            bif.cycle_req = (k < req_len);
            bif.cpu_addr  = a;
            bif.cpu_rw    = rw;
            bif.cpu_wdata = wd;
            bif.bus_rdata = rd;
            bif.usb_ready = (k >= ready_at);
            #1;
            if (bif.rom_select) r_rom++;
            if (bif.ram_select) r_ram++;
            if (bif.usb_select) r_usb++;
            if (!bif.ram_we_n)  r_we++;
            if (!bif.mrdy)      r_mrdy++;
            if (k == 1)         r_wdata = bif.bus_wdata;
            if (bif.cycle_done) begin
                r_n_done++;
                if (r_done_k < 0) begin
                    r_done_k = k;
                    r_rdata  = bif.cpu_rdata;
                end
            end
            @(posedge clk); #1;
        end
        bif.cycle_req = 1'b0;
        bif.usb_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bif.cycle_req = 1'b0; bif.cpu_addr = '0; bif.cpu_rw = 1'b1; bif.cpu_wdata = '0;
        bif.bus_rdata = 8'hFF; bif.usb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({bif.rom_select, bif.ram_select, bif.usb_select} !== 3'b000) $display("FAIL reset_selects: got %b expected 000", {bif.rom_select, bif.ram_select, bif.usb_select}); else passed++;
        total++; if ({bif.ram_we_n, bif.mrdy, bif.cycle_done, bif.bus_error} !== 4'b1100) $display("FAIL reset_ctl: got %b expected 1100", {bif.ram_we_n, bif.mrdy, bif.cycle_done, bif.bus_error}); else passed++;
        total++; if (bif.cpu_rdata !== 8'hFF) $display("FAIL reset_rdata: got %h expected ff", bif.cpu_rdata); else passed++;
        total++; if (bif.bus_wdata !== 8'h00) $display("FAIL reset_wdata: got %h expected 00", bif.bus_wdata); else passed++;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_rom_read();
        run_cycle(16'hFFFE, 1'b1, 8'h00, 8'h5A, 0, 1, 5);
        total++; if (r_done_k !== 2) $display("FAIL rom_rd_done: got %0d expected 2", r_done_k); else passed++;
        total++; if (r_rom !== 1 || r_ram !== 0 || r_usb !== 0) $display("FAIL rom_rd_sel: got rom=%0d ram=%0d usb=%0d expected 1/0/0", r_rom, r_ram, r_usb); else passed++;
        total++; if (r_mrdy !== 2) $display("FAIL rom_rd_mrdy: got %0d expected 2", r_mrdy); else passed++;
        total++; if (r_rdata !== 8'h5A) $display("FAIL rom_rd_data: got %h expected 5a", r_rdata); else passed++;
    endtask

    task automatic test_ram_write();
        run_cycle(16'h1234, 1'b0, 8'hC3, 8'h00, 0, 1, 6);
        total++; if (r_done_k !== 3) $display("FAIL ram_wr_done: got %0d expected 3", r_done_k); else passed++;
        total++; if (r_ram !== 2 || r_we !== 2) $display("FAIL ram_wr_strobe: got sel=%0d we=%0d expected 2/2", r_ram, r_we); else passed++;
        total++; if (r_wdata !== 8'hC3) $display("FAIL ram_wr_wdata: got %h expected c3", r_wdata); else passed++;
        total++; if (r_mrdy !== 3) $display("FAIL ram_wr_mrdy: got %0d expected 3", r_mrdy); else passed++;
    endtask

    task automatic test_ram_read();
        run_cycle(16'h0010, 1'b1, 8'h00, 8'h96, 0, 1, 6);
        total++; if (r_done_k !== 3 || r_rdata !== 8'h96) $display("FAIL ram_rd: got done=%0d data=%h expected 3/96", r_done_k, r_rdata); else passed++;
        total++; if (r_we !== 0) $display("FAIL ram_rd_we: got %0d expected 0", r_we); else passed++;
    endtask

    task automatic test_usb_read();
        run_cycle(16'hA001, 1'b1, 8'h00, 8'h3C, 8, 1, 12);
        total++; if (r_done_k !== 9) $display("FAIL usb_rd_done: got %0d expected 9", r_done_k); else passed++;
        total++; if (r_usb !== 8 || r_rom !== 0 || r_ram !== 0) $display("FAIL usb_rd_sel: got usb=%0d rom=%0d ram=%0d expected 8/0/0", r_usb, r_rom, r_ram); else passed++;
        total++; if (r_rdata !== 8'h3C) $display("FAIL usb_rd_data: got %h expected 3c", r_rdata); else passed++;
`ifndef BUS_TIMEOUT_EN
        total++; if (bif.bus_error !== 1'b0) $display("FAIL usb_no_error: got %b expected 0", bif.bus_error); else passed++;
`endif
    endtask

    task automatic test_unmapped_and_rom_write();
        run_cycle(16'h9000, 1'b1, 8'h00, 8'h77, 0, 1, 5);
        total++; if (r_done_k !== 2 || r_rdata !== 8'hFF) $display("FAIL unmapped_rd: got done=%0d data=%h expected 2/ff", r_done_k, r_rdata); else passed++;
        total++; if (r_rom + r_ram + r_usb !== 0) $display("FAIL unmapped_sel: got %0d expected 0", r_rom + r_ram + r_usb); else passed++;
        run_cycle(16'hE000, 1'b0, 8'h11, 8'h22, 0, 1, 5);
        total++; if (r_done_k !== 2 || r_rom !== 1 || r_we !== 0) $display("FAIL rom_wr: got done=%0d rom=%0d we=%0d expected 2/1/0", r_done_k, r_rom, r_we); else passed++;
        total++; if (bif.cpu_rdata !== 8'hFF) $display("FAIL rom_wr_rdata_kept: got %h expected ff", bif.cpu_rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        // request held through ACCESS and DONE must not start a second cycle
        run_cycle(16'h0200, 1'b1, 8'h00, 8'h4D, 0, 4, 9);
        total++; if (r_n_done !== 1 || r_done_k !== 3) $display("FAIL ignore_busy_req: got dones=%0d first=%0d expected 1/3", r_n_done, r_done_k); else passed++;
        total++; if (r_ram !== 2) $display("FAIL ignore_busy_sel: got %0d expected 2", r_ram); else passed++;
        run_cycle(16'hFFFF, 1'b1, 8'h00, 8'hA5, 0, 1, 4);
        total++; if (r_done_k !== 2 || r_rdata !== 8'hA5) $display("FAIL b2b_rom: got done=%0d data=%h expected 2/a5", r_done_k, r_rdata); else passed++;
    endtask

    task automatic test_reset_mid_cycle();
        bif.cycle_req = 1'b1; bif.cpu_addr = 16'h1234; bif.cpu_rw = 1'b0; bif.cpu_wdata = 8'h5E;
        @(posedge clk); #1;
        bif.cycle_req = 1'b0;
        total++; if (bif.ram_select !== 1'b1 || bif.ram_we_n !== 1'b0) $display("FAIL midrst_pre: got sel=%b we_n=%b expected 1/0", bif.ram_select, bif.ram_we_n); else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++; if ({bif.ram_select, bif.ram_we_n, bif.mrdy, bif.cycle_done} !== 4'b0110) $display("FAIL midrst_drop: got %b expected 0110", {bif.ram_select, bif.ram_we_n, bif.mrdy, bif.cycle_done}); else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        r_n_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (bif.cycle_done) r_n_done++;
        end
        total++; if (r_n_done !== 0) $display("FAIL midrst_no_done: got %0d expected 0", r_n_done); else passed++;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        run_cycle(16'hA000, 1'b1, 8'h00, 8'h3C, 1000, 1, 12);
        total++; if (r_done_k !== 7 || r_rdata !== 8'hFF) $display("FAIL timeout_done: got done=%0d data=%h expected 7/ff", r_done_k, r_rdata); else passed++;
        total++; if (bif.bus_error !== 1'b1) $display("FAIL timeout_err: got %b expected 1", bif.bus_error); else passed++;
        run_cycle(16'hFFFE, 1'b1, 8'h00, 8'h12, 0, 1, 4);
        total++; if (bif.bus_error !== 1'b1 || r_rdata !== 8'h12) $display("FAIL timeout_sticky: got err=%b data=%h expected 1/12", bif.bus_error, r_rdata); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_rom_read();
        test_ram_write();
        test_ram_read();
        test_usb_read();
        test_unmapped_and_rom_write();
        test_back_to_back();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
